// File: rtl/demux_frame_router_pkg.sv
// Shared types and constants for the serial frame router feeding a 1x8 demux.
package demux_frame_router_pkg;
    localparam int SEL_W  = 3;
    localparam int FCNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;
endpackage

// File: rtl/demux_frame_router_if.sv
// Frame-router bus: serial frame input side plus demux-facing outputs.
interface demux_frame_router_if;
    import demux_frame_router_pkg::*;

    logic              start;
    logic              abort;
    logic              sdi;
    logic [SEL_W-1:0]  sel;
    logic              din;
    logic              valid;
    logic              busy;
    logic              done;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (output start, abort, sdi,
                    input  sel, din, valid, busy, done, frame_cnt);
    modport slave  (input  start, abort, sdi,
                    output sel, din, valid, busy, done, frame_cnt);
endinterface

// File: rtl/demux_frame_router_sipo.sv
// MSB-first serial-in parallel-out shift register with load enable.
module sipo_shift_reg #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    assign q_d = {q_q[W-2:0], d_i};
    assign q_o = q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       q_q <= '0;
        else if (en_i) q_q <= q_d;
    end
endmodule

// File: rtl/demux_frame_router.sv
// Serial frame front-end: captures a 3-bit channel address, then streams the
// payload to the demux with sel held stable for the whole payload.
module demux_frame_router
    import demux_frame_router_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    demux_frame_router_if.slave bus
);
    localparam int               CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_BITS - 1);

    state_e            state_q;
    logic [1:0]        addr_cnt_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [SEL_W-1:0]  sel_q;
    logic              din_q, valid_q, done_q;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic [SEL_W-2:0]  addr_hi;

    // Only the first two address bits are stored; the third is taken straight
    // from sdi so sel updates on the third address edge in one step.
    sipo_shift_reg #(.W(SEL_W - 1)) u_addr_sr (
        .clk  (clk),
        .rst  (rst),
        .en_i (state_q == ADDR && !bus.abort),
        .d_i  (bus.sdi),
        .q_o  (addr_hi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            sel_q       <= '0;
            din_q       <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            din_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    state_q    <= ADDR;
                    addr_cnt_q <= '0;
                end
                ADDR: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else begin
                        addr_cnt_q <= addr_cnt_q + 2'd1;
                        if (addr_cnt_q == 2'd2) begin
                            sel_q     <= {addr_hi, bus.sdi};
                            bit_cnt_q <= '0;
                            state_q   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else begin
                        din_q     <= bus.sdi;
                        valid_q   <= 1'b1;
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST) begin
                            done_q      <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
                            state_q     <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sel       = sel_q;
    assign bus.din       = din_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_demux_frame_router.sv
// Frame-level checker for demux_frame_router: the model tracks only the last
// routed address and the completed-frame count; per-cycle outputs follow from them.
module tb_demux_frame_router;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [2:0] ref_sel = '0;
    logic [7:0] ref_cnt = '0;

    demux_frame_router_if bus ();

    demux_frame_router #(.DATA_BITS(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},  32'(bus.busy),      32'd0);
        chk({tag, ".valid"}, 32'(bus.valid),     32'd0);
        chk({tag, ".din"},   32'(bus.din),       32'd0);
        chk({tag, ".done"},  32'(bus.done),      32'd0);
        chk({tag, ".sel"},   32'(bus.sel),       32'(ref_sel));
        chk({tag, ".cnt"},   32'(bus.frame_cnt), 32'(ref_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ab);
        for (int i = 0; i < n; i++) begin
            bus.start = 1'b0;
            bus.abort = ab;
            bus.sdi   = 1'($urandom);
            tick();
            chk_idle("idle");
        end
        bus.abort = 1'b0;
    endtask

    // kind: 0 = clean frame, 1 = abort, 2 = async reset. pos: 0..2 address
    // bit index, 3+k payload bit k. noise pulses start while busy.
    task automatic frame(input logic [2:0] a, input logic [DB-1:0] p,
                         input int kind, input int pos, input bit noise, input bit sa);
        bus.start = 1'b1;
        bus.abort = sa;
        bus.sdi   = 1'($urandom);
        tick();
        chk("start.busy",  32'(bus.busy),  32'd1);
        chk("start.valid", 32'(bus.valid), 32'd0);
        chk("start.sel",   32'(bus.sel),   32'(ref_sel));
        for (int i = 0; i < 3; i++) begin
            bus.start = noise ? 1'($urandom) : 1'b0;
            bus.abort = (kind == 1 && pos == i);
            bus.sdi   = a[2-i];
            tick();
            if (kind == 1 && pos == i) begin
                bus.abort = 1'b0;
                chk_idle("abort_addr");
                return;
            end
            if (i == 2) ref_sel = a;
            chk("addr.sel",   32'(bus.sel),   32'(ref_sel));
            chk("addr.busy",  32'(bus.busy),  32'd1);
            chk("addr.valid", 32'(bus.valid), 32'd0);
        end
        for (int k = 0; k < DB; k++) begin
            bus.start = noise ? 1'($urandom) : 1'b0;
            bus.abort = (kind == 1 && pos == 3 + k);
            bus.sdi   = p[DB-1-k];
            if (kind == 2 && pos == 3 + k) begin
                #2 rst = 1'b1;
                #1;
                ref_sel = '0;
                ref_cnt = '0;
                chk_idle("reset_mid");
                @(negedge clk);
                rst       = 1'b0;
                bus.start = 1'b0;
                return;
            end
            tick();
            if (kind == 1 && pos == 3 + k) begin
                bus.abort = 1'b0;
                chk_idle("abort_data");
                return;
            end
            if (k == DB - 1) ref_cnt = ref_cnt + 8'd1;
            chk("data.din",   32'(bus.din),       32'(p[DB-1-k]));
            chk("data.valid", 32'(bus.valid),     32'd1);
            chk("data.done",  32'(bus.done),      32'(k == DB - 1));
            chk("data.busy",  32'(bus.busy),      32'(k != DB - 1));
            chk("data.sel",   32'(bus.sel),       32'(ref_sel));
            chk("data.cnt",   32'(bus.frame_cnt), 32'(ref_cnt));
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.sdi   = 1'b0;
        #12;
        chk_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        idle(2, 1'b1);                                // abort in IDLE ignored
        frame(3'b101, 4'b1101, 0, 0, 1'b0, 1'b0);     // sel=5, din 1,1,0,1
        idle(1, 1'b0);
        frame(3'b000, 4'b1111, 0, 0, 1'b0, 1'b0);     // back-to-back A then B
        frame(3'b111, 4'b1010, 0, 0, 1'b0, 1'b0);
        chk("b2b.cnt", 32'(bus.frame_cnt), 32'd3);
        idle(1, 1'b0);
        frame(3'b110, 4'b0110, 0, 0, 1'b1, 1'b0);     // start while busy ignored
        idle(1, 1'b0);
        frame(3'b011, 4'b1001, 1, 4, 1'b0, 1'b0);     // abort at 2nd payload edge
        chk("abort.sel", 32'(bus.sel), 32'd3);
        frame(3'b001, 4'b0101, 1, 1, 1'b0, 1'b0);     // abort in ADDR keeps sel
        chk("abort_addr.sel", 32'(bus.sel), 32'd3);
        frame(3'b100, 4'b0011, 0, 0, 1'b0, 1'b1);     // start wins over abort
        idle(1, 1'b0);
        frame(3'b110, 4'b1110, 2, 4, 1'b0, 1'b0);     // reset during 2nd payload bit
        frame(3'b010, 4'b1011, 0, 0, 1'b0, 1'b0);
        chk("post_reset.cnt", 32'(bus.frame_cnt), 32'd1);
        idle(1, 1'b0);

        for (int s = 0; s < 8; s++)
            frame(3'(s), 4'($urandom), 0, 0, 1'b0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            frame(3'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) == 0) ? 1 : 0,
                  int'($urandom_range(0, DB + 2)),
                  1'($urandom), 1'($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)), 1'($urandom));
        end

        for (int f = 0; f < 256; f++)
            frame(3'($urandom), 4'($urandom), 0, 0, 1'b0, 1'b0);
        idle(1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
